// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALUOp codes and datapath mux selects, reused by ALU_control and the datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath, with a memory-ready
// handshake, per-access wait timeout and unsupported-opcode flag.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       bus_error
);

    // The state register is the package enum, so its width is fixed there.
    if (STATE_W != $bits(state_t)) begin : g_bad_state_w
        $error("STATE_W must equal the width of mips_pkg::state_t");
    end
    if (MEM_TIMEOUT < 1 || (2 ** CNT_W) <= MEM_TIMEOUT) begin : g_bad_timeout
        $error("need MEM_TIMEOUT >= 1 and 2**CNT_W > MEM_TIMEOUT");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    assign timeout = !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            // Non-wait states always leave after one cycle, so only the
            // FETCH/MEM_RD/MEM_WR stalls ever see the counter advance.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (!mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;

        unique case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    bus_error  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:     state_next = S_RTYPE_EX;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    bus_error  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    bus_error  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_RTYPE_EX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class,
// memory stalls, the wait timeout boundary, illegal opcode and mid-access reset.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       memto_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, bus_error;

    int tests = 0;
    int fails = 0;

    mips_multicycle_control #(
        .STATE_W(4),
        .MEM_TIMEOUT(16),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .mem_ready(mem_ready),
        .PCWrite(pc_write),
        .PCWriteCond(pc_write_cond),
        .IorD(iord),
        .MemRead(mem_read),
        .MemWrite(mem_write),
        .IRWrite(ir_write),
        .MemtoReg(memto_reg),
        .RegDst(reg_dst),
        .RegWrite(reg_write),
        .ALUSrcA(alu_src_a),
        .ALUSrcB(alu_src_b),
        .ALUOp(alu_op),
        .PCSource(pc_source),
        .illegal_op(illegal_op),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Packed order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    //               RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] illegal bus_err
    localparam logic [17:0] E_IDLE     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_FETCH_RDY= 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_FETCH_WT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_FETCH_TO = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_1;
    localparam logic [17:0] E_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] E_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [17:0] E_MEM_ADDR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_MEM_RD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEM_WB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [17:0] E_MEM_WR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_RTYPE_EX = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] E_RTYPE_WB = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [17:0] E_ADDI_EX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_ADDI_WB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [17:0] E_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [17:0] E_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;

    logic [17:0] observed;
    assign observed = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, illegal_op, bus_error};

    // Inputs for the cycle are set before calling; outputs are checked at the
    // falling edge, then the bench moves just past the next rising edge.
    task automatic cyc(input logic [17:0] expected, input string tag);
        @(negedge clk);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(E_IDLE, "reset_held");
        rst_n = 1'b1;
        cyc(E_IDLE, "idle_after_reset");

        // R-type, mem_ready tied high
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        cyc(E_FETCH_RDY, "r_fetch");
        cyc(E_DECODE,    "r_decode");
        cyc(E_RTYPE_EX,  "r_ex");
        cyc(E_RTYPE_WB,  "r_wb");

        // lw with a 3-cycle read stall; opcode disturbed while it is not sampled
        opcode = 6'b100011;
        cyc(E_FETCH_RDY, "r_back_fetch_lw_fetch");
        cyc(E_DECODE,    "lw_decode");
        cyc(E_MEM_ADDR,  "lw_addr");
        mem_ready = 1'b0;
        opcode    = 6'b101011;
        cyc(E_MEM_RD, "lw_rd_wait1");
        cyc(E_MEM_RD, "lw_rd_wait2");
        cyc(E_MEM_RD, "lw_rd_wait3");
        mem_ready = 1'b1;
        cyc(E_MEM_RD, "lw_rd_done");
        cyc(E_MEM_WB, "lw_wb");

        // sw
        opcode = 6'b101011;
        cyc(E_FETCH_RDY, "sw_fetch");
        cyc(E_DECODE,    "sw_decode");
        cyc(E_MEM_ADDR,  "sw_addr");
        cyc(E_MEM_WR,    "sw_wr");

        // addi
        opcode = 6'b001000;
        cyc(E_FETCH_RDY, "addi_fetch");
        cyc(E_DECODE,    "addi_decode");
        cyc(E_ADDI_EX,   "addi_ex");
        cyc(E_ADDI_WB,   "addi_wb");

        // beq and j
        opcode = 6'b000100;
        cyc(E_FETCH_RDY, "beq_fetch");
        cyc(E_DECODE,    "beq_decode");
        cyc(E_BRANCH,    "beq_branch");
        opcode = 6'b000010;
        cyc(E_FETCH_RDY, "j_fetch");
        cyc(E_DECODE,    "j_decode");
        cyc(E_JUMP,      "j_jump");

        // illegal opcode: one-cycle flag, straight back to FETCH
        opcode = 6'b111111;
        cyc(E_FETCH_RDY, "ill_fetch");
        cyc(E_DEC_ILL,   "ill_decode");
        opcode = 6'b000000;
        mem_ready = 1'b0;
        cyc(E_FETCH_WT,  "ill_back_fetch");

        // Timeout in FETCH: ill_back_fetch was wait cycle 1, so 14 more plain waits
        for (int i = 0; i < 14; i++) cyc(E_FETCH_WT, "to_wait");
        cyc(E_FETCH_TO, "to_bus_error_cycle16");
        cyc(E_IDLE,     "to_idle");

        // Same boundary but mem_ready arrives on the 16th cycle
        for (int i = 0; i < 15; i++) cyc(E_FETCH_WT, "to2_wait");
        mem_ready = 1'b1;
        opcode    = 6'b000010;
        cyc(E_FETCH_RDY, "to2_ready_on_16th");
        cyc(E_DECODE,    "to2_decode");
        cyc(E_JUMP,      "to2_jump");

        // Reset while MEM_WR is stalled
        opcode = 6'b101011;
        cyc(E_FETCH_RDY, "rst_sw_fetch");
        cyc(E_DECODE,    "rst_sw_decode");
        cyc(E_MEM_ADDR,  "rst_sw_addr");
        mem_ready = 1'b0;
        cyc(E_MEM_WR,    "rst_sw_wr_wait");
        rst_n = 1'b0;
        cyc(E_MEM_WR,    "rst_sw_wr_at_reset");
        rst_n = 1'b1;
        cyc(E_IDLE,      "rst_idle_after");
        cyc(E_FETCH_WT,  "rst_fetch_follows");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
